alu_seq: RTL

Parametrised, registered successor of the combinational datapath ALU. It accepts one operation per start pulse and returns a registered result plus N/V/Z/C flags with a one-cycle done strobe. Binary operations finish in one cycle. Decimal-mode ADC/SBC run nibble-serial over several cycles. It sits between the operand latches and the flag register in the execution unit and supports datapaths wider than 8 bits.

---
 rtl/alu_seq.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered ALU returning a result plus N/V/Z/C flags and a one-cycle
// done strobe. Operands are captured on an accepted start and the result is
// committed one edge later (binary ops) or after WIDTH/4 nibble steps (decimal
// ADC/SBC). Decimal mode is built only when ALU_SEQ_BCD_EN is defined; without
// it bcd_i is ignored and busy_o is tied low.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       op_i,
  input  logic             c_in_i,
  input  logic             bcd_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] y_o,
  output logic             zero_o,
  output logic             negative_o,
  output logic             overflow_o,
  output logic             c_out_o
);

  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_ADC = 4'h0;
  localparam logic [3:0] OP_SBC = 4'h1;
  localparam logic [3:0] OP_OR  = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_EOR = 4'h4;
  localparam logic [3:0] OP_INC = 4'h5;
  localparam logic [3:0] OP_DEC = 4'h6;
  localparam logic [3:0] OP_ASL = 4'h7;
  localparam logic [3:0] OP_ROL = 4'h8;
  localparam logic [3:0] OP_ROR = 4'h9;
  localparam logic [3:0] OP_LSR = 4'hA;
  localparam logic [3:0] OP_BIT = 4'hB;
  localparam logic [3:0] OP_CMP = 4'hC;

  // captured operation
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic             cin_q, cin_d;
  logic             pend_q, pend_d;   // binary op captured, commits next edge

  // architectural outputs
  logic [WIDTH-1:0] y_q, y_d;
  logic             z_q, z_d, n_q, n_d, v_q, v_d, c_q, c_d;
  logic             done_q, done_d;

  // binary datapath on the captured operands
  logic [WIDTH:0]   sum_w, sbc_w, cmp_w;
  logic [WIDTH-1:0] by;
  logic             bz, bn, bv, bc;

`ifdef ALU_SEQ_BCD_EN
  // state     | meaning
  // S_IDLE    | ready; start accepted
  // S_DEC_NIB | decimal ADC/SBC, one nibble (k_q) per cycle, LSB first
  typedef enum logic {S_IDLE, S_DEC_NIB} state_t;

  localparam int NIB = WIDTH / 4;
  localparam int KW  = $clog2(NIB);
  localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             cy_q, cy_d;       // carry (ADC) or borrow (SBC) between nibbles
  logic [WIDTH-1:0] part_q, part_d;   // corrected result built so far

  logic [3:0]       a_nib, b_nib, nib_res;
  logic [4:0]       nib_s;
  logic             nib_cy;
  logic [WIDTH-1:0] part_nx;

  assign busy_o = (state_q == S_DEC_NIB);

  // One decimal digit step: add/subtract with a 6 correction when the digit leaves 0..9
  always_comb begin
    a_nib = a_q[4*k_q +: 4];
    b_nib = b_q[4*k_q +: 4];
    if (op_q == OP_SBC) begin
      nib_s   = {1'b0, b_nib} - {1'b0, a_nib} - {4'b0000, cy_q};
      nib_cy  = nib_s[4];
      nib_res = nib_s[4] ? (nib_s[3:0] - 4'd6) : nib_s[3:0];
    end else begin
      nib_s   = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, cy_q};
      nib_cy  = (nib_s > 5'd9);
      nib_res = nib_cy ? (nib_s[3:0] + 4'd6) : nib_s[3:0];
    end
    part_nx = part_q;
    part_nx[4*k_q +: 4] = nib_res;
  end
`else
  logic unused_bcd;
  assign unused_bcd = bcd_i;
  assign busy_o     = 1'b0;
`endif

  // Binary result and flags; decimal overflow is also taken from here
  always_comb begin
    sum_w = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
    sbc_w = {1'b0, b_q} - {1'b0, a_q} - {{WIDTH{1'b0}}, ~cin_q};
    cmp_w = {1'b0, b_q} - {1'b0, a_q};
    by = '0;
    bc = 1'b0;
    bv = 1'b0;
    case (op_q)
      OP_ADC: begin
        by = sum_w[MSB:0];
        bc = sum_w[WIDTH];
        bv = (a_q[MSB] == b_q[MSB]) & (sum_w[MSB] != a_q[MSB]);
      end
      OP_SBC: begin
        by = sbc_w[MSB:0];
        bc = ~sbc_w[WIDTH];
        bv = (a_q[MSB] != b_q[MSB]) & (sbc_w[MSB] != b_q[MSB]);
      end
      OP_OR:  begin by = a_q | b_q; bc = cin_q; end
      OP_AND: begin by = a_q & b_q; bc = cin_q; end
      OP_EOR: begin by = a_q ^ b_q; bc = cin_q; end
      OP_INC: begin by = a_q + 1'b1; bc = cin_q; end
      OP_DEC: begin by = a_q - 1'b1; bc = cin_q; end
      OP_ASL: begin by = {a_q[MSB-1:0], 1'b0};  bc = a_q[MSB]; end
      OP_ROL: begin by = {a_q[MSB-1:0], cin_q}; bc = a_q[MSB]; end
      OP_ROR: begin by = {cin_q, a_q[MSB:1]};   bc = a_q[0];   end
      OP_LSR: begin by = {1'b0, a_q[MSB:1]};    bc = a_q[0];   end
      OP_BIT: begin by = a_q & b_q; bc = cin_q; end
      OP_CMP: begin by = cmp_w[MSB:0]; bc = ~cmp_w[WIDTH]; end
      default: ;
    endcase
    bz = (by == '0);
    bn = by[MSB];
    if (op_q == OP_BIT) begin
      bz = ((a_q & b_q) == '0);
      bn = b_q[MSB];
      bv = b_q[MSB-1];
    end
  end

  // Next state: capture on start, commit binary or step the nibble FSM
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    op_d   = op_q;
    cin_d  = cin_q;
    pend_d = 1'b0;
    done_d = 1'b0;
    y_d    = y_q;
    z_d    = z_q;
    n_d    = n_q;
    v_d    = v_q;
    c_d    = c_q;
`ifdef ALU_SEQ_BCD_EN
    state_d = state_q;
    k_d     = k_q;
    cy_d    = cy_q;
    part_d  = part_q;
`endif
    if (pend_q) begin
      y_d    = by;
      z_d    = bz;
      n_d    = bn;
      v_d    = bv;
      c_d    = bc;
      done_d = 1'b1;
    end
`ifdef ALU_SEQ_BCD_EN
    if (state_q == S_DEC_NIB) begin
      part_d = part_nx;
      cy_d   = nib_cy;
      k_d    = k_q + 1'b1;
      if (k_q == K_LAST) begin
        y_d     = part_nx;
        z_d     = (part_nx == '0);
        n_d     = part_nx[MSB];
        v_d     = bv;
        c_d     = (op_q == OP_SBC) ? ~nib_cy : nib_cy;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    end else if (start_i) begin
      a_d   = a_i;
      b_d   = b_i;
      op_d  = op_i;
      cin_d = c_in_i;
      if (bcd_i && (op_i == OP_ADC || op_i == OP_SBC)) begin
        state_d = S_DEC_NIB;
        k_d     = '0;
        part_d  = '0;
        cy_d    = (op_i == OP_SBC) ? ~c_in_i : c_in_i;
      end else begin
        pend_d = 1'b1;
      end
    end
`else
    if (start_i) begin
      a_d    = a_i;
      b_d    = b_i;
      op_d   = op_i;
      cin_d  = c_in_i;
      pend_d = 1'b1;
    end
`endif
  end

  // State registers; reset aborts any operation in flight
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      cin_q  <= 1'b0;
      pend_q <= 1'b0;
      done_q <= 1'b0;
      y_q    <= '0;
      z_q    <= 1'b0;
      n_q    <= 1'b0;
      v_q    <= 1'b0;
      c_q    <= 1'b0;
`ifdef ALU_SEQ_BCD_EN
      state_q <= S_IDLE;
      k_q     <= '0;
      cy_q    <= 1'b0;
      part_q  <= '0;
`endif
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      op_q   <= op_d;
      cin_q  <= cin_d;
      pend_q <= pend_d;
      done_q <= done_d;
      y_q    <= y_d;
      z_q    <= z_d;
      n_q    <= n_d;
      v_q    <= v_d;
      c_q    <= c_d;
`ifdef ALU_SEQ_BCD_EN
      state_q <= state_d;
      k_q     <= k_d;
      cy_q    <= cy_d;
      part_q  <= part_d;
`endif
    end
  end

  assign done_o     = done_q;
  assign y_o        = y_q;
  assign zero_o     = z_q;
  assign negative_o = n_q;
  assign overflow_o = v_q;
  assign c_out_o    = c_q;

endmodule
